// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU request sequencer: opcodes, ALU control codes,
// FSM state encoding and the signed-overflow helper used on add/sub passes.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_SLT   = 3'd4;
    localparam logic [2:0] OP_ADD64 = 3'd5;
    localparam logic [2:0] OP_SUB64 = 3'd6;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC_LO = 2'd1,
        EXEC_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    // sb_eff is the B sign bit as seen by the adder (after Binvert).
    function automatic logic add_overflow(input logic sa, input logic sb_eff, input logic sr);
        return (sa ~^ sb_eff) & (sr ^ sa);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, response and shared-ALU signals of the sequencer. The slave modport
// is the sequencer's view; master is the view of whatever surrounds it.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_op;
    logic [2*WIDTH-1:0]   in_a;
    logic [2*WIDTH-1:0]   in_b;

    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic                 out_carry;
    logic                 out_zero;
    logic                 out_overflow;
    logic                 out_error;

    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [1:0]           alu_operation;
    logic                 alu_binvert;
    logic                 alu_carryin;
    logic                 alu_carryout;
    logic [WIDTH-1:0]     alu_result;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, alu_carryout, alu_result,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_overflow, out_error,
        output alu_a, alu_b, alu_operation, alu_binvert, alu_carryin
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, alu_carryout, alu_result,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_overflow, out_error,
        input  alu_a, alu_b, alu_operation, alu_binvert, alu_carryin
    );

endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational opcode decode into ALU controls. On the high pass of a wide op
// the carry-in comes from the captured low-pass carry instead of the opcode.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op,
    input  logic       hi_pass,
    input  logic       carry_lo,
    output logic [1:0] operation,
    output logic       binvert,
    output logic       cin,
    output logic       is_wide,
    output logic       is_addsub,
    output logic       is_slt,
    output logic       illegal
);

    always_comb begin
        operation = ALU_AND;
        binvert   = 1'b0;
        is_wide   = 1'b0;
        is_addsub = 1'b0;
        is_slt    = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_AND: begin
                operation = ALU_AND;
            end
            OP_OR: begin
                operation = ALU_OR;
            end
            OP_ADD: begin
                operation = ALU_ADD;
                is_addsub = 1'b1;
            end
            OP_SUB: begin
                operation = ALU_ADD;
                binvert   = 1'b1;
                is_addsub = 1'b1;
            end
            OP_SLT: begin
                operation = ALU_ADD;
                binvert   = 1'b1;
                is_slt    = 1'b1;
            end
            OP_ADD64: begin
                operation = ALU_ADD;
                is_wide   = 1'b1;
                is_addsub = 1'b1;
            end
            OP_SUB64: begin
                operation = ALU_ADD;
                binvert   = 1'b1;
                is_wide   = 1'b1;
                is_addsub = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // Subtraction is A + ~B + 1, so the low-pass carry-in equals Binvert.
        cin = hi_pass ? carry_lo : binvert;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives a shared ripple ALU for one request at a time: one pass for word ops,
// two carry-chained passes for wide add/sub, then holds a registered response.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus
);

    localparam int W = WIDTH;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [W-1:0]       a_hi_q, a_hi_d;
    logic [W-1:0]       b_hi_q, b_hi_d;
    logic [2*W-1:0]     result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [W-1:0]       alu_a_q, alu_a_d;
    logic [W-1:0]       alu_b_q, alu_b_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               alu_binv_q, alu_binv_d;
    logic               alu_cin_q, alu_cin_d;

    logic [2:0]         op_sel;
    logic [1:0]         dec_operation;
    logic               dec_binvert, dec_cin, dec_is_wide, dec_is_addsub, dec_is_slt, dec_illegal;
    logic               pass_ovf;

    // In IDLE the incoming opcode is decoded so the first pass can be loaded on accept.
    assign op_sel = (state_q == IDLE) ? bus.in_op : op_q;

    alu_op_decode u_decode (
        .op        (op_sel),
        .hi_pass   (state_q == EXEC_LO),
        .carry_lo  (bus.alu_carryout),
        .operation (dec_operation),
        .binvert   (dec_binvert),
        .cin       (dec_cin),
        .is_wide   (dec_is_wide),
        .is_addsub (dec_is_addsub),
        .is_slt    (dec_is_slt),
        .illegal   (dec_illegal)
    );

    assign pass_ovf = add_overflow(alu_a_q[W-1], alu_b_q[W-1] ^ alu_binv_q, bus.alu_result[W-1]);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        alu_binv_d = alu_binv_q;
        alu_cin_d  = alu_cin_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d   = bus.in_op;
                    a_hi_d = bus.in_a[2*W-1:W];
                    b_hi_d = bus.in_b[2*W-1:W];
                    if (dec_illegal) begin
                        state_d  = DONE;
                        result_d = '0;
                        carry_d  = 1'b0;
                        ovf_d    = 1'b0;
                        zero_d   = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d    = EXEC_LO;
                        err_d      = 1'b0;
                        alu_a_d    = bus.in_a[W-1:0];
                        alu_b_d    = bus.in_b[W-1:0];
                        alu_op_d   = dec_operation;
                        alu_binv_d = dec_binvert;
                        alu_cin_d  = dec_cin;
                    end
                end
            end
            EXEC_LO: begin
                carry_d  = bus.alu_carryout;
                result_d = '0;
                if (dec_is_slt) begin
                    result_d[0] = bus.alu_result[W-1] ^ pass_ovf;
                end else begin
                    result_d[W-1:0] = bus.alu_result;
                end
                zero_d = ~|result_d;
                ovf_d  = dec_is_addsub & ~dec_is_wide & pass_ovf;
                if (dec_is_wide) begin
                    state_d   = EXEC_HI;
                    alu_a_d   = a_hi_q;
                    alu_b_d   = b_hi_q;
                    alu_cin_d = dec_cin;
                end else begin
                    state_d = DONE;
                end
            end
            EXEC_HI: begin
                carry_d  = bus.alu_carryout;
                result_d = {bus.alu_result, result_q[W-1:0]};
                zero_d   = ~|result_d;
                ovf_d    = pass_ovf;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            alu_binv_q <= 1'b0;
            alu_cin_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_binv_q <= alu_binv_d;
            alu_cin_q  <= alu_cin_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_result    = result_q;
    assign bus.out_carry     = carry_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_error     = err_q;
    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.alu_operation = alu_op_q;
    assign bus.alu_binvert   = alu_binv_q;
    assign bus.alu_carryin   = alu_cin_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ripple ALU on the ALU port and an
// arithmetic reference model of each request, directed cases then random ones.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(W)) bus();

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared ALU: AND/OR/ADD with B inversion; CarryOut always from the adder chain.
    logic [W-1:0] alu_bb;
    logic [W:0]   alu_sum;
    always_comb begin
        alu_bb  = bus.alu_binvert ? ~bus.alu_b : bus.alu_b;
        alu_sum = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {{W{1'b0}}, bus.alu_carryin};
        case (bus.alu_operation)
            2'b00:   bus.alu_result = bus.alu_a & alu_bb;
            2'b01:   bus.alu_result = bus.alu_a | alu_bb;
            2'b10:   bus.alu_result = alu_sum[W-1:0];
            default: bus.alu_result = '0;
        endcase
        bus.alu_carryout = alu_sum[W];
    end

    typedef struct packed {
        logic [63:0] res;
        logic        carry;
        logic        zero;
        logic        ovf;
        logic        err;
    } resp_t;

    int    checks   = 0;
    int    failures = 0;
    resp_t last;

    function automatic resp_t ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        resp_t       r;
        logic [32:0] u32;
        logic [32:0] s32;
        logic [64:0] u65;
        logic [64:0] s65;
        r   = '0;
        u32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        case (op)
            3'd0: begin
                r.res   = {32'b0, a[31:0] & b[31:0]};
                r.carry = u32[32];
            end
            3'd1: begin
                r.res   = {32'b0, a[31:0] | b[31:0]};
                r.carry = u32[32];
            end
            3'd2: begin
                r.res   = {32'b0, u32[31:0]};
                r.carry = u32[32];
                s32     = {a[31], a[31:0]} + {b[31], b[31:0]};
                r.ovf   = s32[32] ^ s32[31];
            end
            3'd3: begin
                r.res   = {32'b0, a[31:0] - b[31:0]};
                r.carry = (a[31:0] >= b[31:0]);
                s32     = {a[31], a[31:0]} - {b[31], b[31:0]};
                r.ovf   = s32[32] ^ s32[31];
            end
            3'd4: begin
                r.res   = {63'b0, ($signed(a[31:0]) < $signed(b[31:0]))};
                r.carry = (a[31:0] >= b[31:0]);
            end
            3'd5: begin
                u65     = {1'b0, a} + {1'b0, b};
                r.res   = u65[63:0];
                r.carry = u65[64];
                s65     = {a[63], a} + {b[63], b};
                r.ovf   = s65[64] ^ s65[63];
            end
            3'd6: begin
                r.res   = a - b;
                r.carry = (a >= b);
                s65     = {a[63], a} - {b[63], b};
                r.ovf   = s65[64] ^ s65[63];
            end
            default: begin
                r.err = 1'b1;
            end
        endcase
        r.zero = (r.res == 64'd0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
        resp_t exp;
        resp_t snap;
        int    lat;
        int    waitc;
        int    exp_lat;
        exp     = ref_model(op, a, b);
        exp_lat = (op == 3'd7) ? 1 : ((op == OP_ADD64 || op == OP_SUB64) ? 3 : 2);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        waitc = 0;
        while (bus.in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("accept_wait", waitc, 0);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                bus.in_valid = 1'b0;
                bus.in_a     = {$urandom, $urandom};
                bus.in_b     = {$urandom, $urandom};
                bus.in_op    = 3'($urandom_range(0, 7));
            end
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 10);
        check("latency", lat, exp_lat);
        snap.res   = bus.out_result;
        snap.carry = bus.out_carry;
        snap.zero  = bus.out_zero;
        snap.ovf   = bus.out_overflow;
        snap.err   = bus.out_error;
        check("result", snap.res, exp.res);
        check("flags_czve", {snap.carry, snap.zero, snap.ovf, snap.err},
              {exp.carry, exp.zero, exp.ovf, exp.err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", {bus.out_valid, bus.out_result, bus.out_carry, bus.out_zero,
                                  bus.out_overflow, bus.out_error}, {1'b1, snap});
            check("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_consume_idle", {bus.out_valid, bus.in_ready}, 2'b01);
        last = snap;
        $display("op=%0d a=%h b=%h res=%h c=%b z=%b v=%b e=%b lat=%0d hold=%0d",
                 op, a, b, snap.res, snap.carry, snap.zero, snap.ovf, snap.err, lat, hold);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [2:0]  rop;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_handshake", {bus.in_ready, bus.out_valid}, 2'b10);
        check("reset_resp", {bus.out_result, bus.out_carry, bus.out_zero, bus.out_overflow, bus.out_error}, '0);
        check("reset_alu", {bus.alu_a, bus.alu_b, bus.alu_operation, bus.alu_binvert, bus.alu_carryin}, '0);
        rst = 1'b0;

        run_op(OP_AND, 64'h0000_0000_a5a5_a5a5, 64'h0000_0000_5a5a_5a5a, 0);
        check("and_const", {last.res, last.zero}, {64'h0, 1'b1});
        run_op(OP_OR,  64'h0000_0000_a5a5_a5a5, 64'h0000_0000_5a5a_5a5a, 0);
        check("or_const", {last.res, last.zero}, {64'hffff_ffff, 1'b0});
        run_op(OP_ADD, 64'h0000_0000_a5a5_a5a5, 64'h0000_0000_5a5a_5a5a, 1);
        check("add_const", {last.res, last.carry, last.ovf}, {64'hffff_ffff, 1'b0, 1'b0});
        run_op(OP_SUB, 64'h0000_0000_a5a5_a5a5, 64'h0000_0000_5a5a_5a5a, 0);
        check("sub_const", {last.res, last.carry}, {64'h4b4b_4b4b, 1'b1});
        run_op(OP_ADD, 64'h0000_0000_7fff_ffff, 64'h0000_0000_0000_0001, 0);
        check("add_ovf_const", {last.res, last.ovf}, {64'h8000_0000, 1'b1});
        run_op(OP_SLT, 64'h0000_0000_ffff_fffb, 64'h0000_0000_0000_0003, 0);
        check("slt_neg_pos", {last.res, last.ovf}, {64'h1, 1'b0});
        run_op(OP_SLT, 64'h0000_0000_0000_0003, 64'h0000_0000_ffff_fffb, 0);
        check("slt_pos_neg", last.res, 64'h0);
        run_op(OP_SLT, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0001, 0);
        check("slt_ovf_path", {last.res, last.ovf}, {64'h1, 1'b0});
        run_op(OP_ADD64, 64'h0000_0000_ffff_ffff, 64'h0000_0000_0000_0001, 0);
        check("add64_const", {last.res, last.carry}, {64'h0000_0001_0000_0000, 1'b0});
        run_op(OP_SUB64, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 0);
        check("sub64_const", {last.res, last.carry}, {64'h0000_0000_ffff_ffff, 1'b1});
        run_op(OP_ADD, 64'h0000_0000_1234_5678, 64'h0000_0000_1111_1111, 5);
        run_op(OP_OR,  64'h0000_0000_0000_00f0, 64'h0000_0000_0000_000f, 0);
        run_op(3'd7,   64'h1234_5678_9abc_def0, 64'h1111_1111_1111_1111, 2);
        check("illegal_const", {last.res, last.zero, last.err}, {64'h0, 1'b1, 1'b1});

        // Reset in the middle of the high pass of a wide add.
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ADD64;
        bus.in_a     = 64'h0000_0042_ffff_ffff;
        bus.in_b     = 64'h0000_0007_0000_0001;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("exec_hi_drive", {bus.alu_a, bus.alu_b, bus.alu_carryin}, {32'h42, 32'h7, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        check("midop_reset_handshake", {bus.out_valid, bus.in_ready}, 2'b01);
        check("midop_reset_alu", {bus.alu_a, bus.alu_b, bus.alu_operation, bus.alu_binvert, bus.alu_carryin}, '0);
        rst = 1'b0;
        run_op(OP_OR, 64'h0000_0000_0f0f_0000, 64'h0000_0000_0000_f0f0, 0);
        check("or_after_reset", last.res, 64'h0f0f_f0f0);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (n % 5 == 0) rb = ra;
            if (n % 7 == 3) ra[31:0] = 32'h8000_0000;
            run_op(rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Request-side driver for the 32-bit ripple ALU. It accepts operation requests over a valid/ready handshake and decodes them into the ALU control inputs `Operation`, `Binvert` and `Carryin`. It drives operands for one or two passes, captures `Result` and `CarryOut`, derives flags, and returns a registered response with a valid/ready handshake. Wide (2*WIDTH) add/sub is done as two carry-chained passes through the same ALU instance. The block sits between the datapath control and the shared ALU.

Parameters:
WIDTH, 32, ALU data width; wide operands and results are 2*WIDTH.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready at clk edge
in_op  in  3  operation code (package constants)
in_a  in  2*WIDTH  operand A (upper half used only by wide ops)
in_b  in  2*WIDTH  operand B
out_valid  out  1  response valid
out_ready  in  1  response consumed when out_valid&out_ready at clk edge
out_result  out  2*WIDTH  result, zero-extended for single-word ops
out_carry  out  1  final ALU CarryOut
out_zero  out  1  out_result == 0
out_overflow  out  1  signed overflow of the final pass (add/sub only, else 0)
out_error  out  1  illegal opcode
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_operation  out  2  to ALU Operation (00 AND, 01 OR, 10 ADD)
alu_binvert  out  1  to ALU Binvert
alu_carryin  out  1  to ALU Carryin
alu_carryout  in  1  from ALU CarryOut
alu_result  in  WIDTH  from ALU Result (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- On reset:
  - state=IDLE; in_ready=1.
  - out_valid=0; out_result=0; out_carry/zero/overflow/error=0.
  - ALU drive outputs all 0.
- Operand and ALU drive registers:
  - Operands are registered on accept; later in_a/in_b changes are ignored.
  - ALU drive outputs are registered.
  - alu_result/alu_carryout are sampled at the end of each EXEC cycle.
- Opcode decode:
  - AND: operation=00, binvert=0, cin=0.
  - OR: operation=01, binvert=0, cin=0.
  - ADD and ADD64: operation=10, binvert=0, cin=0.
  - SUB, SLT, SUB64: operation=10, binvert=1, cin=1 on the low pass.
  - Wide high pass: cin = captured low-pass carry; binvert unchanged.
- FSM states: IDLE, EXEC_LO, EXEC_HI, DONE.
  - IDLE: in_ready=1. On accept, load operands/op and go to EXEC_LO.
  - Illegal opcode (7): go directly to DONE with out_error=1, result=0, carry=0, overflow=0, zero=1.
  - EXEC_LO: drive low words. Capture the result into result[WIDTH-1:0] and the carry.
  - From EXEC_LO: wide ops go to EXEC_HI, others go to DONE.
  - EXEC_HI: drive high words with cin=low carry. Capture into result[2*WIDTH-1:WIDTH] and go to DONE.
  - DONE: out_valid=1 and all out_* are held stable. On out_ready, go to IDLE.
- Latency:
  - Single-word ops: out_valid asserts 2 cycles after the accept edge.
  - Wide ops: 3 cycles. Illegal opcode: 1 cycle.
  - Maximum throughput is one request per 3 (or 4) cycles; no pipelining.
- in_ready=0 in every state except IDLE. No new request is accepted in the cycle DONE is consumed.
- Overflow for add/sub passes: (sa ~^ sb') & (sr ^ sa), where sa, sb', sr are the MSBs of the A operand, the effective B operand (inverted for sub) and the result.
- SLT result = {zeros, res[WIDTH-1] ^ overflow}. Its out_overflow is 0 and out_carry is the raw CarryOut.
- out_zero is computed over the full 2*WIDTH result. Upper half is 0 for single-word ops.
- out_valid held with out_ready=0: all outputs remain frozen indefinitely.
- rst asserted in any state, including mid-EXEC_HI: next edge returns to the reset values; the in-flight op is discarded.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3, OP_SLT=4, OP_ADD64=5, OP_SUB64=6;
  - state encodings;
  - ALU operation codes ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10.
- One combinational sub-module, alu_op_decode: in_op and a pass-select input give operation, binvert, low-pass cin, is_wide and illegal.

Test Plan:
- Bench instantiates alu_op_sequencer with the existing alu.
- AND a=a5a5a5a5, b=5a5a5a5a -> result 00000000, zero=1, out_valid 2 cycles after accept. OR with the same operands -> ffffffff, zero=0.
- ADD a5a5a5a5+5a5a5a5a -> ffffffff, carry=0, overflow=0. SUB same operands -> 4b4b4b4b, carry=1. ADD 7fffffff+1 -> 80000000, overflow=1.
- SLT a=fffffffb, b=00000003 -> 1. SLT a=3, b=fffffffb -> 0. SLT 80000000 vs 00000001 -> 1 (overflow path).
- ADD64 00000000_ffffffff + 00000000_00000001 -> 00000001_00000000, carry=0, latency 3. SUB64 00000001_00000000 - 1 -> 00000000_ffffffff, carry=1.
- out_ready low for 5 cycles in DONE -> outputs stable and in_ready=0. Then accept; a back-to-back request is taken the cycle after. Opcode 7 -> out_error=1, zero=1, latency 1.
- rst pulsed during EXEC_HI of ADD64 -> next cycle out_valid=0, in_ready=1, alu_* = 0. A following OR completes correctly.
